// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// Writable 16 x 8 program memory with a byte-serial load port. A host streams
// up to 16 instruction bytes over a valid/ready handshake into consecutive
// addresses starting at 0. The CPU fetch side reads the array combinationally
// by 4-bit address. While a load is in progress the CPU is held off and a
// running mod-256 checksum of the written bytes is kept.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   load_start   in   one-cycle load request, honoured only in IDLE
//   load_len     in   [3:0] words minus one, sampled with load_start
//   load_abort   in   terminate a load, honoured only in LOAD
//   wr_data      in   [7:0] instruction byte from host
//   wr_valid     in   wr_data is valid
//   wr_ready     out  byte accepted this cycle (LOAD only)
//   rd_addr      in   [3:0] CPU fetch address
//   rd_data      out  [7:0] mem[rd_addr], combinational
//   cpu_hold     out  high whenever not IDLE
//   load_done    out  one-cycle pulse on successful completion
//   load_aborted out  sticky abort flag, cleared by next accepted load_start
//   checksum     out  [7:0] mod-256 sum of bytes written in current/last load

module prog_mem_loader #(
  parameter logic [7:0] FILL = 8'hB0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic [3:0] load_len,
  input  logic       load_abort,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_aborted,
  output logic [7:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] addr;
  logic [3:0] last;
  logic [7:0] mem [16];
  logic       start_ok;
  logic       abort_ok;
  logic       xfer;

  // Qualified events. Abort wins over a byte presented in the same cycle, so
  // that byte is neither written nor summed.
  assign start_ok = (state == IDLE) && load_start;
  assign abort_ok = (state == LOAD) && load_abort;
  assign xfer     = (state == LOAD) && wr_valid && !load_abort;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and output decode; outputs depend on registered state only,
  // so there is no combinational path from wr_valid to wr_ready/cpu_hold.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    cpu_hold   = 1'b0;
    load_done  = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        cpu_hold = 1'b1;
        if (load_abort) begin
          state_next = IDLE;
        end else if (wr_valid && (addr == last)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        cpu_hold   = 1'b1;
        load_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Load bookkeeping: address counter, last address, checksum, abort flag.
  // The counter only advances when the current word is not the last one,
  // so last=15 ends at address 15 without wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr         <= 4'd0;
      last         <= 4'd0;
      checksum     <= 8'd0;
      load_aborted <= 1'b0;
    end else begin
      if (start_ok) begin
        addr         <= 4'd0;
        last         <= load_len;
        checksum     <= 8'd0;
        load_aborted <= 1'b0;
      end else if (abort_ok) begin
        load_aborted <= 1'b1;
      end else if (xfer) begin
        checksum <= checksum + wr_data;
        if (addr != last) begin
          addr <= addr + 4'd1;
        end
      end
    end
  end

  // Memory array; reset refills every word so a reset mid-load discards
  // whatever the partial load had written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= FILL;
      end
    end else if (xfer) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
